// File: rtl/bus_demux_1to4.sv
// Single-outstanding 1-to-4 address-decoded bus demux between the CPU load/store
// unit and four SoC slaves, with registered slave-side request fields and a timeout.
module bus_demux_1to4 #(
  parameter int unsigned     AW     = 32,
  parameter int unsigned     DW     = 32,
  parameter logic [AW-1:0]   BASE0  = 32'h0000_0000,
  parameter logic [AW-1:0]   BASE1  = 32'h1000_0000,
  parameter logic [AW-1:0]   BASE2  = 32'h2000_0000,
  parameter logic [AW-1:0]   BASE3  = 32'h3000_0000,
  parameter logic [AW-1:0]   MASK   = 32'hF000_0000,
  parameter int unsigned     TO_CYC = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW-1:0]   req_addr_i,
  input  logic            req_we_i,
  input  logic [3:0]      req_be_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [3:0]      s_valid_o,
  input  logic [3:0]      s_ready_i,
  output logic [AW-1:0]   s_addr_o,
  output logic            s_we_o,
  output logic [3:0]      s_be_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic [3:0]      s_rvalid_i,
  input  logic [4*DW-1:0] s_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    s_valid_q, s_valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [2:0]    dec;
  logic [DW-1:0] sel_rdata;

  // Returns {hit, index}; earlier slaves take priority when windows overlap.
  function automatic logic [2:0] decode(input logic [AW-1:0] a);
    if ((a & MASK) == (BASE0 & MASK)) return 3'b100;
    if ((a & MASK) == (BASE1 & MASK)) return 3'b101;
    if ((a & MASK) == (BASE2 & MASK)) return 3'b110;
    if ((a & MASK) == (BASE3 & MASK)) return 3'b111;
    return 3'b000;
  endfunction

  assign dec       = decode(req_addr_i);
  assign sel_rdata = s_rdata_i[int'(sel_q)*DW +: DW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    s_valid_d   = s_valid_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          be_d    = req_be_i;
          wdata_d = req_wdata_i;
          sel_d   = dec[1:0];
          cnt_d   = '0;
          if (dec[2]) begin
            state_d   = REQ;
            s_valid_d = 4'b0001 << dec[1:0];
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (s_ready_i[sel_q]) begin
          s_valid_d = '0;
          cnt_d     = '0;
          // A slave may accept and answer in the same cycle.
          if (s_rvalid_i[sel_q]) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : sel_rdata;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q == TO_LIM) begin
          s_valid_d   = '0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (s_rvalid_i[sel_q]) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : sel_rdata;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TO_LIM) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      s_valid_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      s_valid_q   <= s_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign s_valid_o   = s_valid_q;
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_be_o      = be_q;
  assign s_wdata_o   = wdata_q;

endmodule
